// File: rtl/fighter_pkg.sv
// Shared types and default timing constants for the fighter input, physics and hit logic.
package fighter_pkg;

  localparam int unsigned Y_W      = 7;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DB_CNT_W = 3;

  localparam int unsigned FLOOR_Y_DEFAULT           = 48;
  localparam int unsigned DEBOUNCE_TICKS_DEFAULT    = 2;
  localparam int unsigned STARTUP_TICKS_DEFAULT     = 2;
  localparam int unsigned ACTIVE_TICKS_DEFAULT      = 3;
  localparam int unsigned RECOVER_TICKS_DEFAULT     = 4;
  localparam int unsigned JUMP_BUFFER_TICKS_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOVE    = 3'd1,
    ST_STARTUP = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_RECOVER = 3'd4
  } atk_state_t;

  // Walking only happens when exactly one direction is held.
  function automatic logic exactly_one(input logic left, input logic right);
    return left ^ right;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, filtered level and registered rise strobe.
module btn_debounce
  import fighter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);

  logic                sync1_q, sync2_q;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  // Level follows the synchronised value only after it has disagreed for DEBOUNCE_TICKS cycles.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_CNT_W'(DEBOUNCE_TICKS - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/fighter_input_ctrl.sv
// Per-player command generator: debounced buttons, attack FSM, movement and jump commands.
// Optional jump buffering is enabled by defining FIGHTER_JUMP_BUFFER_EN.
module fighter_input_ctrl
  import fighter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS    = DEBOUNCE_TICKS_DEFAULT,
  parameter int unsigned FLOOR_Y           = FLOOR_Y_DEFAULT,
  parameter int unsigned STARTUP_TICKS     = STARTUP_TICKS_DEFAULT,
  parameter int unsigned ACTIVE_TICKS      = ACTIVE_TICKS_DEFAULT,
  parameter int unsigned RECOVER_TICKS     = RECOVER_TICKS_DEFAULT,
  parameter int unsigned JUMP_BUFFER_TICKS = JUMP_BUFFER_TICKS_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_up,
  input  logic           btn_attack,
  input  logic [Y_W-1:0] sprite_y,
  output logic           movingLeft,
  output logic           movingRight,
  output logic           isJumping,
  output logic           attack_busy,
  output logic           attack_hit
);

  logic left_f, right_f, up_f, atk_f;
  logic up_rise, atk_rise;
  logic left_rise_unused, right_rise_unused;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_left (
    .clk(clk), .rst_n(reset), .btn_raw_i(btn_left), .level_o(left_f), .rise_o(left_rise_unused)
  );
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_right (
    .clk(clk), .rst_n(reset), .btn_raw_i(btn_right), .level_o(right_f), .rise_o(right_rise_unused)
  );
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_up (
    .clk(clk), .rst_n(reset), .btn_raw_i(btn_up), .level_o(up_f), .rise_o(up_rise)
  );
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_attack (
    .clk(clk), .rst_n(reset), .btn_raw_i(btn_attack), .level_o(atk_f), .rise_o(atk_rise)
  );

  atk_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_left_q, move_left_d;
  logic             move_right_q, move_right_d;
  logic             jump_q, jump_d;
  logic             busy_q, busy_d;
  logic             hit_q, hit_d;
  logic             move_sel;
  logic             on_floor;
  logic             can_jump;

  assign move_sel = exactly_one(left_f, right_f);
  assign on_floor = (sprite_y == Y_W'(FLOOR_Y));
  assign can_jump = on_floor && ((state_q == ST_IDLE) || (state_q == ST_MOVE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      jump_q       <= 1'b0;
      busy_q       <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      jump_q       <= jump_d;
      busy_q       <= busy_d;
      hit_q        <= hit_d;
    end
  end

  // Attack FSM; one down-counter times all three attack phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_MOVE: begin
        if (atk_rise) begin
          state_d = ST_STARTUP;
          cnt_d   = CNT_W'(STARTUP_TICKS - 1);
        end else if (move_sel) begin
          state_d = ST_MOVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STARTUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = CNT_W'(ACTIVE_TICKS - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = CNT_W'(RECOVER_TICKS - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = move_sel ? ST_MOVE : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    move_left_d  = 1'b0;
    move_right_d = 1'b0;
    busy_d       = 1'b0;
    hit_d        = 1'b0;
    if (state_d == ST_MOVE) begin
      move_left_d  = left_f && !right_f;
      move_right_d = right_f && !left_f;
    end
    if ((state_d == ST_STARTUP) || (state_d == ST_ACTIVE) || (state_d == ST_RECOVER)) begin
      busy_d = 1'b1;
    end
    if (state_d == ST_ACTIVE) begin
      hit_d = 1'b1;
    end
  end

`ifdef FIGHTER_JUMP_BUFFER_EN
  logic [CNT_W-1:0] jbuf_q, jbuf_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jbuf_q <= '0;
    end else begin
      jbuf_q <= jbuf_d;
    end
  end

  // A jump request that cannot be honoured now is kept alive for JUMP_BUFFER_TICKS cycles.
  always_comb begin
    jump_d = 1'b0;
    jbuf_d = jbuf_q;
    if (can_jump && (up_rise || (jbuf_q != '0))) begin
      jump_d = 1'b1;
      jbuf_d = '0;
    end else if (up_rise) begin
      jbuf_d = CNT_W'(JUMP_BUFFER_TICKS);
    end else if (jbuf_q != '0) begin
      jbuf_d = jbuf_q - CNT_W'(1);
    end
  end
`else
  logic jbuf_unused;
  assign jbuf_unused = ^(32'(JUMP_BUFFER_TICKS));

  always_comb begin
    jump_d = up_rise && can_jump;
  end
`endif

  assign movingLeft  = move_left_q;
  assign movingRight = move_right_q;
  assign isJumping   = jump_q;
  assign attack_busy = busy_q;
  assign attack_hit  = hit_q;

endmodule

// File: tb/tb_fighter_input_ctrl.sv
// Directed bench for fighter_input_ctrl: movement, debounce, jump, attack timeline and reset abort.
module tb_fighter_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_left, btn_right, btn_up, btn_attack;
  logic [6:0] sprite_y;
  logic       movingLeft, movingRight, isJumping, attack_busy, attack_hit;

  int checks = 0;
  int errors = 0;

  fighter_input_ctrl dut (
    .clk        (clk),
    .reset      (rst_n),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_attack (btn_attack),
    .sprite_y   (sprite_y),
    .movingLeft (movingLeft),
    .movingRight(movingRight),
    .isJumping  (isJumping),
    .attack_busy(attack_busy),
    .attack_hit (attack_hit)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n edges and return how many of them produced an isJumping pulse.
  task automatic count_jumps(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (isJumping === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int busy_seen;
    logic exp_busy, exp_hit, exp_mr;

    rst_n = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_attack = 1'b0;
    sprite_y = 7'd48;
    tick(3);
    check("rst_left", movingLeft, 0);
    check("rst_right", movingRight, 0);
    check("rst_jump", isJumping, 0);
    check("rst_busy", attack_busy, 0);
    check("rst_hit", attack_hit, 0);
    rst_n = 1'b1;
    tick(2);

    // Right press: output at edge 5, release drops it five edges later
    btn_right = 1'b1;
    tick(4);
    check("right_e4", movingRight, 0);
    tick(1);
    check("right_e5", movingRight, 1);
    check("right_e5_left", movingLeft, 0);
    btn_right = 1'b0;
    tick(4);
    check("rel_e4", movingRight, 1);
    tick(1);
    check("rel_e5", movingRight, 0);

    // One-cycle glitch on left is filtered out
    btn_left = 1'b1;
    tick(1);
    btn_left = 1'b0;
    tick(3);
    check("glitch_e4", movingLeft, 0);
    tick(3);
    check("glitch_e7", movingLeft, 0);

    // Both directions together give no movement
    btn_left = 1'b1; btn_right = 1'b1;
    tick(6);
    check("both_left", movingLeft, 0);
    check("both_right", movingRight, 0);
    tick(4);
    check("both_left_late", movingLeft, 0);
    btn_left = 1'b0; btn_right = 1'b0;
    tick(8);

    // Left alone
    btn_left = 1'b1;
    tick(5);
    check("left_e5", movingLeft, 1);
    check("left_e5_right", movingRight, 0);
    btn_left = 1'b0;
    tick(8);
    check("left_released", movingLeft, 0);

    // Jump on the floor: one pulse at edge 5, none while held
    btn_up = 1'b1;
    tick(4);
    check("jump_e4", isJumping, 0);
    tick(1);
    check("jump_e5", isJumping, 1);
    tick(1);
    check("jump_e6", isJumping, 0);
    count_jumps(10, pulses);
    check("jump_hold", pulses, 0);
    btn_up = 1'b0;
    tick(8);

    // Airborne up press is dropped (buffered request also expires while still airborne)
    sprite_y = 7'd30;
    btn_up = 1'b1;
    count_jumps(12, pulses);
    check("jump_air", pulses, 0);
    btn_up = 1'b0;
    tick(8);
    sprite_y = 7'd48;
    tick(2);

    // Attack while walking right; attack rise seen at edge 4
    btn_right = 1'b1;
    tick(5);
    check("pre_atk_right", movingRight, 1);
    btn_attack = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      exp_busy = (k >= 5) && (k <= 13);
      exp_hit  = (k >= 7) && (k <= 9);
      exp_mr   = !exp_busy;
      check($sformatf("atk_busy_e%0d", k), attack_busy, exp_busy);
      check($sformatf("atk_hit_e%0d", k), attack_hit, exp_hit);
      check($sformatf("atk_right_e%0d", k), movingRight, exp_mr);
    end
    busy_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (attack_busy === 1'b1) busy_seen++;
    end
    check("atk_hold_no_retrigger", busy_seen, 0);
    btn_attack = 1'b0;
    btn_right = 1'b0;
    tick(8);
    check("atk_done_right", movingRight, 0);

`ifdef FIGHTER_JUMP_BUFFER_EN
    // Buffered jump: landing two cycles after the rise still jumps
    sprite_y = 7'd45;
    btn_up = 1'b1;
    tick(6);
    check("jbuf_e6", isJumping, 0);
    sprite_y = 7'd48;
    tick(1);
    check("jbuf_land", isJumping, 1);
    count_jumps(6, pulses);
    check("jbuf_single", pulses, 0);
    btn_up = 1'b0;
    sprite_y = 7'd45;
    tick(8);
    // Landing after the buffer has expired does nothing
    btn_up = 1'b1;
    tick(8);
    sprite_y = 7'd48;
    count_jumps(4, pulses);
    check("jbuf_expired", pulses, 0);
    btn_up = 1'b0;
    tick(8);
`endif

    // Reset mid-ACTIVE aborts the attack asynchronously
    btn_attack = 1'b1;
    tick(7);
    check("abort_pre_hit", attack_hit, 1);
    check("abort_pre_busy", attack_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_hit", attack_hit, 0);
    check("abort_busy", attack_busy, 0);
    btn_attack = 1'b0;
    tick(2);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if ((attack_busy | attack_hit | movingLeft | movingRight | isJumping) === 1'b1) busy_seen++;
    end
    check("post_reset_quiet", busy_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
